// File: rtl/riscv_tag_exception_ctrl.sv
// Tag-violation back end: qualifies the raw tag exception, latches PC/instr/cause, holds a request
// to the controller until ack, then pulses flush; ID is stalled (halt) from capture+1 until flush ends.
module riscv_tag_exception_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic                 tag_exc_i,
  input  logic [2:0]           hit_i,
  input  logic                 id_valid_i,
  input  logic [31:0]          pc_id_i,
  input  logic [31:0]          instr_id_i,
  input  logic                 exc_ack_i,
  input  logic                 cnt_clear_i,
  output logic                 kill_o,
  output logic                 halt_id_o,
  output logic                 exc_req_o,
  output logic [31:0]          exc_pc_o,
  output logic [31:0]          exc_instr_o,
  output logic [2:0]           exc_cause_o,
  output logic                 flush_o,
  output logic                 missed_o,
  output logic [CNT_WIDTH-1:0] exc_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic [2:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 missed_q, missed_d;

  logic qual;
  logic capture;

  assign qual    = enable_i & tag_exc_i & id_valid_i;
  assign capture = qual & (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      cause_q  <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      missed_q <= missed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)   state_d = REQ;
      REQ:     if (exc_ack_i) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture fields and bookkeeping; a clear coinciding with a capture still counts that capture.
  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    if (capture) begin
      pc_d    = pc_id_i;
      instr_d = instr_id_i;
      cause_d = hit_i;
    end
    if (cnt_clear_i) begin
      cnt_d    = capture ? CNT_ONE : '0;
      missed_d = 1'b0;
    end else begin
      if (capture && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
      if (qual && (state_q != IDLE))     missed_d = 1'b1;
    end
  end

  // Moore decode of the state flop, so these drop as soon as reset hits the state register.
  always_comb begin
    exc_req_o = 1'b0;
    halt_id_o = 1'b0;
    flush_o   = 1'b0;
    case (state_q)
      REQ: begin
        exc_req_o = 1'b1;
        halt_id_o = 1'b1;
      end
      FLUSH: begin
        flush_o   = 1'b1;
        halt_id_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign kill_o      = capture;
  assign exc_pc_o    = pc_q;
  assign exc_instr_o = instr_q;
  assign exc_cause_o = cause_q;
  assign exc_cnt_o   = cnt_q;
  assign missed_o    = missed_q;

endmodule
